// File: rtl/bmu_issue_queue.sv
// Request buffer in front of the BMU: screens control encodings, queues legal
// requests and issues at most one per cycle through a registered output stage.
module bmu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_a,
  input  logic [31:0]              req_b,
  input  logic [21:0]              req_ap,
  input  logic                     req_csr_ren,
  input  logic [31:0]              req_csr_rddata,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     valid_in,
  output logic [31:0]              a_in,
  output logic [31:0]              b_in,
  output logic [21:0]              ap,
  output logic                     csr_ren_in,
  output logic [31:0]              csr_rddata_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         illegal_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [21:0] ap;
    logic        csr_ren;
    logic [31:0] csr_rddata;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          req_e;
  entry_t          out_q;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            valid_q;
  logic [CNT_W-1:0] ill_q;

  logic [4:0] op_ones;
  logic       legal;
  logic       accept;
  logic       acc_legal;
  logic       acc_illegal;
  logic       fifo_empty;
  logic       do_pop;
  logic       do_bypass;
  logic       do_push;

  assign req_e = '{a: req_a, b: req_b, ap: req_ap,
                   csr_ren: req_csr_ren, csr_rddata: req_csr_rddata};

  // Exactly one op bit, or a bare CSR write with no op bit.
  assign op_ones = 5'($countones(req_ap[21:6]));
  assign legal   = (op_ones == 5'd1) || ((op_ones == 5'd0) && req_ap[0]);

  assign fifo_empty  = (count_q == '0);
  assign req_ready   = (count_q < CW'(DEPTH));
  assign accept      = req_valid && req_ready;
  assign acc_legal   = accept && legal && !flush;
  assign acc_illegal = accept && !legal && !flush;
  assign do_pop      = !hold && !flush && !fifo_empty;
  assign do_bypass   = !hold && !flush && fifo_empty && acc_legal;
  assign do_push     = acc_legal && !do_bypass;

  // Storage array carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= req_e;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        out_q  <= mem[rd_ptr];
      end else if (do_bypass) begin
        out_q  <= req_e;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      valid_q <= do_pop || do_bypass;
    end
  end

  // Saturating drop counter, survives flush.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ill_q <= '0;
    end else if (acc_illegal && (ill_q != {CNT_W{1'b1}})) begin
      ill_q <= ill_q + CNT_W'(1);
    end
  end

  assign valid_in      = valid_q;
  assign a_in          = out_q.a;
  assign b_in          = out_q.b;
  assign ap            = out_q.ap;
  assign csr_ren_in    = out_q.csr_ren;
  assign csr_rddata_in = out_q.csr_rddata;
  assign count         = count_q;
  assign illegal_cnt   = ill_q;

endmodule

// File: tb/tb_bmu_issue_queue.sv
// Bench for bmu_issue_queue: directed plan steps plus random traffic, checked
// against a queue-based reference model.
module tb_bmu_issue_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic        clk;
  logic        rst_l;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [21:0] req_ap;
  logic        req_csr_ren;
  logic [31:0] req_csr_rddata;
  logic        hold;
  logic        flush;
  logic        valid_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [21:0] ap;
  logic        csr_ren_in;
  logic [31:0] csr_rddata_in;
  logic [2:0]  count;
  logic [7:0]  illegal_cnt;

  bmu_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ap(req_ap),
    .req_csr_ren(req_csr_ren), .req_csr_rddata(req_csr_rddata),
    .hold(hold), .flush(flush),
    .valid_in(valid_in), .a_in(a_in), .b_in(b_in), .ap(ap),
    .csr_ren_in(csr_ren_in), .csr_rddata_in(csr_rddata_in),
    .count(count), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [21:0] ap;
    logic        ren;
    logic [31:0] rd;
  } ent_t;

  ent_t mq[$];
  ent_t m_out;
  logic m_valid;
  int   m_ill;
  int   n_pass;
  int   n_total;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [21:0] c);
    int n;
    n = 0;
    for (int i = 6; i < 22; i++) n += int'(c[i]);
    return (n == 1) || (n == 0 && c[0] == 1'b1);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out   = '{32'h0, 32'h0, 22'h0, 1'b0, 32'h0};
    m_valid = 1'b0;
    m_ill   = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    ent_t r;
    bit   was_empty;
    bit   issued;
    bit   acc;
    r = '{req_a, req_b, req_ap, req_csr_ren, req_csr_rddata};
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      acc       = req_valid && (mq.size() < DEPTH);
      was_empty = (mq.size() == 0);
      issued    = 1'b0;
      if (!hold && !was_empty) begin
        m_out  = mq.pop_front();
        issued = 1'b1;
      end
      if (acc && is_legal(req_ap)) begin
        if (!hold && was_empty) begin
          m_out  = r;
          issued = 1'b1;
        end else begin
          mq.push_back(r);
        end
      end else if (acc && m_ill < SAT) begin
        m_ill++;
      end
      m_valid = issued;
    end
  endtask

  task automatic check_all(input string t);
    check({t, "_valid"}, 32'(valid_in), 32'(m_valid));
    check({t, "_count"}, 32'(count), 32'(mq.size()));
    check({t, "_ready"}, 32'(req_ready), 32'(mq.size() < DEPTH));
    check({t, "_ill"}, 32'(illegal_cnt), 32'(m_ill));
    check({t, "_a"}, a_in, m_out.a);
    check({t, "_b"}, b_in, m_out.b);
    check({t, "_ap"}, 32'(ap), 32'(m_out.ap));
    check({t, "_ren"}, 32'(csr_ren_in), 32'(m_out.ren));
    check({t, "_rd"}, csr_rddata_in, m_out.rd);
  endtask

  task automatic cycle(input string t);
    model_step();
    @(posedge clk);
    #1;
    check_all(t);
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [21:0] c);
    req_valid      = v;
    req_a          = a;
    req_b          = b;
    req_ap         = c;
    req_csr_ren    = 1'($urandom_range(0, 1));
    req_csr_rddata = $urandom;
  endtask

  function automatic logic [21:0] rand_ap();
    logic [21:0] c;
    int          k;
    c = 22'($urandom);
    k = int'($urandom_range(0, 3));
    if (k == 0)      c = {16'h0001 << $urandom_range(0, 15), c[5:0]};
    else if (k == 1) c = {16'h0, c[5:1], 1'b1};
    else if (k == 2) c = {(16'h0001 << $urandom_range(0, 7)) | (16'h0100 << $urandom_range(0, 7)), c[5:0]};
    return c;
  endfunction

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    rst_l = 1'b0; hold = 1'b0; flush = 1'b0;
    set_req(1'b0, 32'h0, 32'h0, 22'h0);
    model_reset();
    #12;
    check_all("reset");
    rst_l = 1'b1;

    // Single add request bypasses straight to the output register.
    set_req(1'b1, 32'h5, 32'h3, 22'h0_2000);
    cycle("single");
    check("single_ap_const", 32'(ap), 32'h0_2000);
    check("single_a_const", a_in, 32'h5);
    set_req(1'b0, 32'h0, 32'h0, 22'h0);
    cycle("single_after");

    // Fill under hold, fifth push refused, then drain in order.
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), 22'h0_0040 << i);
      cycle("fill");
    end
    check("full_ready", 32'(req_ready), 32'h0);
    check("full_count", 32'(count), 32'd4);
    set_req(1'b0, 32'h0, 32'h0, 22'h0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("drain");
      check("drain_order", a_in, 32'h100 + 32'(i));
    end
    cycle("drain_idle");

    // Two illegal encodings dropped, bare CSR write issued.
    set_req(1'b1, 32'h11, 32'h22, 22'h0_00C0);
    cycle("illeg0");
    set_req(1'b1, 32'h33, 32'h44, 22'h0);
    cycle("illeg1");
    set_req(1'b1, 32'h55, 32'h66, 22'h0_0001);
    cycle("csrw");
    check("csrw_ap_const", 32'(ap), 32'h1);
    check("csrw_ill_const", 32'(illegal_cnt), 32'd2);
    set_req(1'b0, 32'h0, 32'h0, 22'h0);
    cycle("csrw_after");

    // Flush wins over a same-cycle push; nothing issues afterwards.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, $urandom, $urandom, 22'h1 << (6 + i));
      cycle("preflush");
    end
    flush = 1'b1;
    set_req(1'b1, 32'hAA, 32'hBB, 22'h0_2000);
    cycle("flush");
    check("flush_count_const", 32'(count), 32'd0);
    flush = 1'b0; hold = 1'b0;
    set_req(1'b0, 32'h0, 32'h0, 22'h0);
    for (int i = 0; i < 3; i++) cycle("postflush");

    // Saturate the illegal counter and keep pushing.
    for (int i = 0; i < SAT + 2; i++) begin
      set_req(1'b1, $urandom, $urandom, 22'h0_00C0);
      cycle("sat");
    end
    check("sat_const", 32'(illegal_cnt), 32'(SAT));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_req(1'($urandom_range(0, 3) != 0), $urandom, $urandom, rand_ap());
      hold  = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end
    flush = 1'b0; hold = 1'b0;
    set_req(1'b0, 32'h0, 32'h0, 22'h0);
    for (int i = 0; i < 6; i++) cycle("rand_drain");

    // Asynchronous reset while an entry is on the pins and two are queued.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 32'hC0 + 32'(i), 32'hD0 + 32'(i), 22'h0_2000);
      cycle("prerst");
    end
    hold = 1'b0;
    set_req(1'b0, 32'h0, 32'h0, 22'h0);
    cycle("prerst_pop");
    check("prerst_valid_const", 32'(valid_in), 32'h1);
    check("prerst_count_const", 32'(count), 32'd2);
    #2;
    rst_l = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst_valid_const", 32'(valid_in), 32'h0);
    @(posedge clk);
    #2;
    rst_l = 1'b1;
    set_req(1'b1, 32'h77, 32'h88, 22'h0_4000);
    cycle("after_rst");
    set_req(1'b0, 32'h0, 32'h0, 22'h0);
    cycle("after_rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
